// File: rtl/rvh_l1d_pkg.sv
// L1D shared definitions.
// Holds the MESI line-state encoding used by the L1D bank, the line state
// table, the snoop path and the miss/refill logic. Also holds the default
// LR/SC reservation lifetime.
// No ports (package).
package rvh_l1d_pkg;

  // MESI coherence state of one cache line. INVALID must stay all-zeros
  // because the line state table resets its whole array to zero.
  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } rrv64_mesi_type_e;

  // Width of one packed MESI field on flattened ports.
  localparam int unsigned MESI_W = $bits(rrv64_mesi_type_e);

  // Default number of cycles an LR reservation stays alive.
  localparam int unsigned L1D_RSV_TIMEOUT = 64;

endpackage

// File: rtl/rvh_l1d_plru_tree.sv
// Combinational tree-PLRU helper for one set.
// Node 0 is the root; node n has children 2n+1 (lower half of the ways)
// and 2n+2 (upper half). A node bit of 1 means "victim is in the upper half".
// Ports:
//   bits_i        current PLRU bits of the set (WAY_NUM-1 nodes)
//   touch_way_i   way being accessed
//   bits_o        PLRU bits after touching touch_way_i
//   victim_way_o  victim way selected by walking bits_i from the root
module rvh_l1d_plru_tree #(
  parameter  int unsigned WAY_NUM = 4,
  localparam int unsigned WAY_W   = $clog2(WAY_NUM)
) (
  input  logic [WAY_NUM-2:0] bits_i,
  input  logic [WAY_W-1:0]   touch_way_i,
  output logic [WAY_NUM-2:0] bits_o,
  output logic [WAY_W-1:0]   victim_way_o
);

  // One extra bit so the walk index can reach the leaf level without wrap.
  localparam int unsigned NODE_W = WAY_W + 1;

  logic [NODE_W-1:0] touchIdx;
  logic              touchDir;
  logic [NODE_W-1:0] victimIdx;
  logic              victimDir;

  // Walk from the root towards the touched way, one level per way-index bit
  // (MSB first). Every node on the path is flipped to point at the other
  // half, so the just-used way is the last to be picked. Nodes are matched
  // by comparison rather than indexed directly so that the walk index can
  // be one bit wider than the node vector.
  always_comb begin
    bits_o   = bits_i;
    touchIdx = '0;
    touchDir = 1'b0;
    for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
      touchDir = touch_way_i[WAY_W-1-lvl];
      for (int n = 0; n < int'(WAY_NUM) - 1; n++) begin
        if (NODE_W'(n) == touchIdx) begin
          bits_o[n] = ~touchDir;
        end
      end
      touchIdx = (touchIdx << 1) + NODE_W'(1) + NODE_W'(touchDir);
    end
  end

  // Follow the node bits from the root; each bit taken is one victim-way
  // bit, MSB first, and also selects which child to visit next.
  always_comb begin
    victim_way_o = '0;
    victimIdx    = '0;
    victimDir    = 1'b0;
    for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
      victimDir = 1'b0;
      for (int n = 0; n < int'(WAY_NUM) - 1; n++) begin
        if (NODE_W'(n) == victimIdx) begin
          victimDir = bits_i[n];
        end
      end
      victim_way_o[WAY_W-1-lvl] = victimDir;
      victimIdx = (victimIdx << 1) + NODE_W'(1) + NODE_W'(victimDir);
    end
  end

endmodule

// File: rtl/rvh_l1d_lst_plru.sv
// L1D line state table with tree-PLRU replacement and an LR/SC reservation.
// Stores a MESI state per (set, way), a PLRU tree per set, and one
// reservation with a timeout.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr_vld_i/wr_set_i/wr_way_i/
//   wr_mesi_i                     prioritised MESI write ports (port 0 wins)
//   rd_set_i / rd_mesi_o          read ports, all way states of a set
//   touch_vld_i/_set_i/_way_i     PLRU access update
//   victim_set_i / victim_way_o /
//   victim_inv_o                  replacement victim for a set
//   rsv_set_i/_set_idx_i/_way_idx_i  create LR reservation
//   rsv_clr_i                     clear reservation
//   rsv_chk_set_i/_way_i/_ok_o    reservation check
module rvh_l1d_lst_plru
  import rvh_l1d_pkg::*;
#(
  parameter  int unsigned SET_NUM     = 32,
  parameter  int unsigned WAY_NUM     = 4,
  parameter  int unsigned WR_PORT_NUM = 2,
  parameter  int unsigned RD_PORT_NUM = 2,
  parameter  int unsigned RSV_TIMEOUT = L1D_RSV_TIMEOUT,
  localparam int unsigned SET_W       = $clog2(SET_NUM),
  localparam int unsigned WAY_W       = $clog2(WAY_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WR_PORT_NUM-1:0]                wr_vld_i,
  input  logic [WR_PORT_NUM*SET_W-1:0]          wr_set_i,
  input  logic [WR_PORT_NUM*WAY_W-1:0]          wr_way_i,
  input  logic [WR_PORT_NUM*MESI_W-1:0]         wr_mesi_i,
  input  logic [RD_PORT_NUM*SET_W-1:0]          rd_set_i,
  output logic [RD_PORT_NUM*WAY_NUM*MESI_W-1:0] rd_mesi_o,
  input  logic                                  touch_vld_i,
  input  logic [SET_W-1:0]                      touch_set_i,
  input  logic [WAY_W-1:0]                      touch_way_i,
  input  logic [SET_W-1:0]                      victim_set_i,
  output logic [WAY_W-1:0]                      victim_way_o,
  output logic                                  victim_inv_o,
  input  logic                                  rsv_set_i,
  input  logic [SET_W-1:0]                      rsv_set_idx_i,
  input  logic [WAY_W-1:0]                      rsv_way_idx_i,
  input  logic                                  rsv_clr_i,
  input  logic [SET_W-1:0]                      rsv_chk_set_i,
  input  logic [WAY_W-1:0]                      rsv_chk_way_i,
  output logic                                  rsv_chk_ok_o
);

  localparam int unsigned CNT_W = $clog2(RSV_TIMEOUT) + 1;

  rrv64_mesi_type_e   mesi_q [SET_NUM][WAY_NUM];
  rrv64_mesi_type_e   mesi_d [SET_NUM][WAY_NUM];
  logic [WAY_NUM-2:0] plru_q [SET_NUM];
  logic [WAY_NUM-2:0] plru_d [SET_NUM];

  logic               rsvVld_q, rsvVld_d;
  logic [SET_W-1:0]   rsvSet_q, rsvSet_d;
  logic [WAY_W-1:0]   rsvWay_q, rsvWay_d;
  logic [CNT_W-1:0]   rsvCnt_q, rsvCnt_d;
  logic               rsvWrHit;

  logic [WAY_NUM-2:0] touchBits;
  logic [WAY_W-1:0]   plruVictim;
  logic [WAY_W-1:0]   invWay;
  logic               victimInv;
  logic [WAY_W-1:0]   unusedTouchVictim;
  logic [WAY_NUM-2:0] unusedVictimBits;

  // Merge all write ports into the next MESI array. Ports are applied from
  // the highest index down so that the lowest valid port targeting a line
  // is applied last and therefore wins; writes to distinct lines all land.
  always_comb begin
    mesi_d = mesi_q;
    for (int p = int'(WR_PORT_NUM) - 1; p >= 0; p--) begin
      if (wr_vld_i[p]) begin
        mesi_d[wr_set_i[p*SET_W +: SET_W]][wr_way_i[p*WAY_W +: WAY_W]] =
          rrv64_mesi_type_e'(wr_mesi_i[p*MESI_W +: MESI_W]);
      end
    end
  end

  // Read ports look straight at the stored array, so a write in the same
  // cycle is not visible until the following cycle.
  always_comb begin
    rd_mesi_o = '0;
    for (int p = 0; p < int'(RD_PORT_NUM); p++) begin
      for (int w = 0; w < int'(WAY_NUM); w++) begin
        rd_mesi_o[(p*WAY_NUM+w)*MESI_W +: MESI_W] =
          mesi_q[rd_set_i[p*SET_W +: SET_W]][w];
      end
    end
  end

  // Tree used to compute the updated PLRU bits of the touched set; its
  // victim output is not needed here.
  rvh_l1d_plru_tree #(
    .WAY_NUM (WAY_NUM)
  ) u_touch_tree (
    .bits_i       (plru_q[touch_set_i]),
    .touch_way_i  (touch_way_i),
    .bits_o       (touchBits),
    .victim_way_o (unusedTouchVictim)
  );

  // Tree used to walk the victim set; its touch output is not needed here.
  rvh_l1d_plru_tree #(
    .WAY_NUM (WAY_NUM)
  ) u_victim_tree (
    .bits_i       (plru_q[victim_set_i]),
    .touch_way_i  ('0),
    .bits_o       (unusedVictimBits),
    .victim_way_o (plruVictim)
  );

  // Only touches move the PLRU state; MESI writes leave it alone, so a touch
  // and a write to the same set in one cycle both take effect.
  always_comb begin
    plru_d = plru_q;
    if (touch_vld_i) begin
      plru_d[touch_set_i] = touchBits;
    end
  end

  // An empty way is always the cheapest victim, so prefer the lowest-index
  // INVALID way and only fall back to the PLRU choice when the set is full.
  always_comb begin
    victimInv = 1'b0;
    invWay    = '0;
    for (int w = int'(WAY_NUM) - 1; w >= 0; w--) begin
      if (mesi_q[victim_set_i][w] == INVALID) begin
        victimInv = 1'b1;
        invWay    = WAY_W'(w);
      end
    end
    victim_way_o = victimInv ? invWay : plruVictim;
    victim_inv_o = victimInv;
  end

  // Any valid write port that lands on the reserved line breaks the
  // reservation, whatever state it writes.
  always_comb begin
    rsvWrHit = 1'b0;
    for (int p = 0; p < int'(WR_PORT_NUM); p++) begin
      if (wr_vld_i[p] &&
          (wr_set_i[p*SET_W +: SET_W] == rsvSet_q) &&
          (wr_way_i[p*WAY_W +: WAY_W] == rsvWay_q)) begin
        rsvWrHit = 1'b1;
      end
    end
  end

  // Reservation next state. A new LR always takes over, even over a clear
  // in the same cycle. Otherwise a live reservation counts down and dies on
  // clear, on a write hit, or when the counter has reached 1, which gives a
  // lifetime of exactly RSV_TIMEOUT cycles.
  always_comb begin
    rsvVld_d = rsvVld_q;
    rsvSet_d = rsvSet_q;
    rsvWay_d = rsvWay_q;
    rsvCnt_d = rsvCnt_q;
    if (rsv_set_i) begin
      rsvVld_d = 1'b1;
      rsvSet_d = rsv_set_idx_i;
      rsvWay_d = rsv_way_idx_i;
      rsvCnt_d = CNT_W'(RSV_TIMEOUT);
    end else if (rsvVld_q) begin
      if (rsv_clr_i || rsvWrHit || (rsvCnt_q == CNT_W'(1))) begin
        rsvVld_d = 1'b0;
        rsvCnt_d = '0;
      end else begin
        rsvCnt_d = rsvCnt_q - CNT_W'(1);
      end
    end
  end

  assign rsv_chk_ok_o = rsvVld_q &&
                        (rsv_chk_set_i == rsvSet_q) &&
                        (rsv_chk_way_i == rsvWay_q);

  // State registers. Reset empties every line, clears all PLRU trees and
  // drops the reservation, overriding any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SET_NUM); s++) begin
        for (int w = 0; w < int'(WAY_NUM); w++) begin
          mesi_q[s][w] <= INVALID;
        end
        plru_q[s] <= '0;
      end
      rsvVld_q <= 1'b0;
      rsvSet_q <= '0;
      rsvWay_q <= '0;
      rsvCnt_q <= '0;
    end else begin
      mesi_q   <= mesi_d;
      plru_q   <= plru_d;
      rsvVld_q <= rsvVld_d;
      rsvSet_q <= rsvSet_d;
      rsvWay_q <= rsvWay_d;
      rsvCnt_q <= rsvCnt_d;
    end
  end

endmodule

// File: tb/tb_rvh_l1d_lst_plru.sv
// Self-checking bench for rvh_l1d_lst_plru using directed vectors with
// hand-computed expectations. Runs with RSV_TIMEOUT=4.
module tb_rvh_l1d_lst_plru;
  import rvh_l1d_pkg::*;

  localparam int unsigned SET_NUM     = 32;
  localparam int unsigned WAY_NUM     = 4;
  localparam int unsigned WR_PORT_NUM = 2;
  localparam int unsigned RD_PORT_NUM = 2;
  localparam int unsigned RSV_TIMEOUT = 4;
  localparam int unsigned SET_W       = 5;
  localparam int unsigned WAY_W       = 2;

  logic                                  clk;
  logic                                  rst;
  logic [WR_PORT_NUM-1:0]                wr_vld_i;
  logic [WR_PORT_NUM*SET_W-1:0]          wr_set_i;
  logic [WR_PORT_NUM*WAY_W-1:0]          wr_way_i;
  logic [WR_PORT_NUM*MESI_W-1:0]         wr_mesi_i;
  logic [RD_PORT_NUM*SET_W-1:0]          rd_set_i;
  logic [RD_PORT_NUM*WAY_NUM*MESI_W-1:0] rd_mesi_o;
  logic                                  touch_vld_i;
  logic [SET_W-1:0]                      touch_set_i;
  logic [WAY_W-1:0]                      touch_way_i;
  logic [SET_W-1:0]                      victim_set_i;
  logic [WAY_W-1:0]                      victim_way_o;
  logic                                  victim_inv_o;
  logic                                  rsv_set_i;
  logic [SET_W-1:0]                      rsv_set_idx_i;
  logic [WAY_W-1:0]                      rsv_way_idx_i;
  logic                                  rsv_clr_i;
  logic [SET_W-1:0]                      rsv_chk_set_i;
  logic [WAY_W-1:0]                      rsv_chk_way_i;
  logic                                  rsv_chk_ok_o;

  int checkCount;
  int failCount;

  rvh_l1d_lst_plru #(
    .SET_NUM     (SET_NUM),
    .WAY_NUM     (WAY_NUM),
    .WR_PORT_NUM (WR_PORT_NUM),
    .RD_PORT_NUM (RD_PORT_NUM),
    .RSV_TIMEOUT (RSV_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_vld_i      (wr_vld_i),
    .wr_set_i      (wr_set_i),
    .wr_way_i      (wr_way_i),
    .wr_mesi_i     (wr_mesi_i),
    .rd_set_i      (rd_set_i),
    .rd_mesi_o     (rd_mesi_o),
    .touch_vld_i   (touch_vld_i),
    .touch_set_i   (touch_set_i),
    .touch_way_i   (touch_way_i),
    .victim_set_i  (victim_set_i),
    .victim_way_o  (victim_way_o),
    .victim_inv_o  (victim_inv_o),
    .rsv_set_i     (rsv_set_i),
    .rsv_set_idx_i (rsv_set_idx_i),
    .rsv_way_idx_i (rsv_way_idx_i),
    .rsv_clr_i     (rsv_clr_i),
    .rsv_chk_set_i (rsv_chk_set_i),
    .rsv_chk_way_i (rsv_chk_way_i),
    .rsv_chk_ok_o  (rsv_chk_ok_o)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation and keep the tallies.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance the given number of clock edges; inputs are then safe to change
  // and outputs are sampled 1 unit after the edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Arm one write port for the next edge.
  task automatic driveWrite(input int port, input int set, input int way,
                            input logic [1:0] mesi);
    wr_vld_i[port]                = 1'b1;
    wr_set_i[port*SET_W +: SET_W] = SET_W'(set);
    wr_way_i[port*WAY_W +: WAY_W] = WAY_W'(way);
    wr_mesi_i[port*MESI_W +: MESI_W] = mesi;
  endtask

  // Drop every one-cycle strobe.
  task automatic clearStrobes();
    wr_vld_i    = '0;
    touch_vld_i = 1'b0;
    rsv_set_i   = 1'b0;
    rsv_clr_i   = 1'b0;
  endtask

  // Read-port slice helper: the 8-bit all-way state vector of port p.
  function automatic logic [7:0] rdSlice(input int p);
    return rd_mesi_o[p*8 +: 8];
  endfunction

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    wr_vld_i = '0; wr_set_i = '0; wr_way_i = '0; wr_mesi_i = '0;
    rd_set_i = '0;
    touch_vld_i = 1'b0; touch_set_i = '0; touch_way_i = '0;
    victim_set_i = '0;
    rsv_set_i = 1'b0; rsv_set_idx_i = '0; rsv_way_idx_i = '0; rsv_clr_i = 1'b0;
    rsv_chk_set_i = '0; rsv_chk_way_i = '0;

    // Reset state.
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(1);
    rd_set_i = {5'd31, 5'd0};
    victim_set_i = 5'd5;
    rsv_chk_set_i = 5'd4; rsv_chk_way_i = 2'd1;
    #1;
    checkOutput("rst_rd0", 32'(rdSlice(0)), 32'h00);
    checkOutput("rst_rd1", 32'(rdSlice(1)), 32'h00);
    checkOutput("rst_victim_way", 32'(victim_way_o), 32'd0);
    checkOutput("rst_victim_inv", 32'(victim_inv_o), 32'd1);
    checkOutput("rst_rsv_ok", 32'(rsv_chk_ok_o), 32'd0);

    // Two ports to the same line: port 0 wins; no same-cycle bypass.
    driveWrite(0, 3, 2, MODIFIED);
    driveWrite(1, 3, 2, INVALID);
    rd_set_i[0 +: SET_W] = 5'd3;
    #1;
    checkOutput("no_bypass", 32'(rdSlice(0)), 32'h00);
    applyStimulus(1);
    clearStrobes();
    #1;
    checkOutput("wr_prio", 32'(rdSlice(0)), 32'h30);

    // Fill set 7 with SHARED using both ports on distinct lines.
    driveWrite(0, 7, 0, SHARED);
    driveWrite(1, 7, 1, SHARED);
    applyStimulus(1);
    driveWrite(0, 7, 2, SHARED);
    driveWrite(1, 7, 3, SHARED);
    applyStimulus(1);
    clearStrobes();
    rd_set_i[SET_W +: SET_W] = 5'd7;
    victim_set_i = 5'd7;
    #1;
    checkOutput("fill_rd", 32'(rdSlice(1)), 32'h55);
    checkOutput("full_victim_init", 32'(victim_way_o), 32'd0);
    checkOutput("full_victim_inv", 32'(victim_inv_o), 32'd0);

    // PLRU sequence: touch 0 -> 2, touch 2 -> 1.
    touch_vld_i = 1'b1; touch_set_i = 5'd7; touch_way_i = 2'd0;
    applyStimulus(1);
    clearStrobes();
    #1;
    checkOutput("plru_t0", 32'(victim_way_o), 32'd2);
    touch_vld_i = 1'b1; touch_way_i = 2'd2;
    applyStimulus(1);
    clearStrobes();
    #1;
    checkOutput("plru_t2", 32'(victim_way_o), 32'd1);

    // Touch 1 together with a write to the same set: both commit.
    touch_vld_i = 1'b1; touch_way_i = 2'd1;
    driveWrite(0, 7, 0, EXCLUSIVE);
    applyStimulus(1);
    clearStrobes();
    #1;
    checkOutput("plru_t1", 32'(victim_way_o), 32'd3);
    checkOutput("touch_wr_rd", 32'(rdSlice(1)), 32'h56);
    checkOutput("touch_wr_inv", 32'(victim_inv_o), 32'd0);

    // Set 9: ways 1 and 3 empty, PLRU at reset points to way 0.
    driveWrite(0, 9, 0, EXCLUSIVE);
    driveWrite(1, 9, 2, MODIFIED);
    applyStimulus(1);
    clearStrobes();
    victim_set_i = 5'd9;
    #1;
    checkOutput("inv_victim_way", 32'(victim_way_o), 32'd1);
    checkOutput("inv_victim_inv", 32'(victim_inv_o), 32'd1);

    // Reservation lifetime of exactly 4 cycles.
    rsv_set_i = 1'b1; rsv_set_idx_i = 5'd4; rsv_way_idx_i = 2'd1;
    applyStimulus(1);
    clearStrobes();
    #1;
    checkOutput("rsv_live_1", 32'(rsv_chk_ok_o), 32'd1);
    rsv_chk_way_i = 2'd2;
    #1;
    checkOutput("rsv_other_way", 32'(rsv_chk_ok_o), 32'd0);
    rsv_chk_way_i = 2'd1;
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("rsv_live_%0d", i), 32'(rsv_chk_ok_o), 32'd1);
    end
    applyStimulus(1);
    checkOutput("rsv_expired", 32'(rsv_chk_ok_o), 32'd0);

    // A snoop write to the reserved line kills the reservation.
    rsv_set_i = 1'b1;
    applyStimulus(1);
    clearStrobes();
    checkOutput("rsv_armed", 32'(rsv_chk_ok_o), 32'd1);
    driveWrite(1, 4, 1, SHARED);
    applyStimulus(1);
    clearStrobes();
    checkOutput("rsv_wr_kill", 32'(rsv_chk_ok_o), 32'd0);

    // New LR in the same cycle as a hitting write keeps it alive.
    rsv_set_i = 1'b1;
    applyStimulus(1);
    clearStrobes();
    rsv_set_i = 1'b1;
    driveWrite(1, 4, 1, EXCLUSIVE);
    applyStimulus(1);
    clearStrobes();
    checkOutput("rsv_set_wins", 32'(rsv_chk_ok_o), 32'd1);

    // Explicit clear.
    rsv_clr_i = 1'b1;
    applyStimulus(1);
    clearStrobes();
    checkOutput("rsv_clr", 32'(rsv_chk_ok_o), 32'd0);

    // Reset mid-operation overrides a simultaneous LR and empties lines.
    rsv_set_i = 1'b1;
    driveWrite(0, 3, 1, MODIFIED);
    rst = 1'b1;
    applyStimulus(1);
    clearStrobes();
    rst = 1'b0;
    rd_set_i[0 +: SET_W] = 5'd3;
    victim_set_i = 5'd7;
    #1;
    checkOutput("midrst_rd", 32'(rdSlice(0)), 32'h00);
    checkOutput("midrst_rsv", 32'(rsv_chk_ok_o), 32'd0);
    checkOutput("midrst_victim_way", 32'(victim_way_o), 32'd0);
    checkOutput("midrst_victim_inv", 32'(victim_inv_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
